// File: rtl/display_share_if.sv
// Bundle between the display requesters and the sharing arbiter that feeds fourDigitDisplay.
interface display_share_if;
  logic [2:0]  req;
  logic [15:0] val0, val1, val2;
  logic [3:0]  dp0, dp1, dp2;
  logic [3:0]  sg0, sg1, sg2;
  logic [2:0]  gnt;
  logic [3:0]  W, X, Y, Z;
  logic [3:0]  decPts;
  logic [3:0]  signs;

  modport master (
    output req, val0, val1, val2, dp0, dp1, dp2, sg0, sg1, sg2,
    input  gnt, W, X, Y, Z, decPts, signs
  );

  modport slave (
    input  req, val0, val1, val2, dp0, dp1, dp2, sg0, sg1, sg2,
    output gnt, W, X, Y, Z, decPts, signs
  );
endinterface

// File: rtl/display_share_arbiter.sv
// Round-robin sharing of one four-digit display among three requesters, with
// min/max hold times counted in prescaled ticks and a blank frame between owners.
module display_share_arbiter #(
  parameter int TICK_DIV = 100000,
  parameter int MIN_HOLD = 500,
  parameter int MAX_HOLD = 3000
) (
  input  logic           CLK,
  input  logic           RESET,
  display_share_if.slave ds
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [1:0] {IDLE, OWN, BLANK} state_t;

  state_t          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      rr_q, rr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [PW-1:0]   cnt_q;
  logic            tick;
  logic [2:0]      gnt_d;
  logic [15:0]     digits_d;
  logic [3:0]      dp_d, sg_d;

  function automatic logic [1:0] next3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Walks the search order backwards so the first hit in forward order wins.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] sel;
    logic [1:0] idx;
    sel = p;
    for (int k = 2; k >= 0; k--) begin
      idx = p;
      for (int s = 0; s < k; s++) idx = next3(idx);
      if (r[idx]) sel = idx;
    end
    return sel;
  endfunction

  assign tick = (cnt_q == PW'(TICK_DIV - 1));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (|ds.req) begin
          owner_d = rr_pick(ds.req, rr_q);
          hold_d  = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        if (tick && (hold_q != HW'(MAX_HOLD))) hold_d = hold_q + 1'b1;
        if (((hold_q >= HW'(MIN_HOLD)) && !ds.req[owner_q]) ||
            ((hold_q >= HW'(MAX_HOLD)) && |(ds.req & ~(3'b001 << owner_q)))) begin
          state_d = BLANK;
          rr_d    = next3(owner_q);
          hold_d  = '0;
        end
      end
      BLANK: begin
        if (tick) begin
          if (|ds.req) begin
            owner_d = rr_pick(ds.req, rr_q);
            hold_d  = '0;
            state_d = OWN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output frame follows the next state so gnt and live data appear on the same edge.
  always_comb begin
    gnt_d    = '0;
    digits_d = '0;
    dp_d     = '0;
    sg_d     = '0;
    case (state_d)
      OWN: begin
        gnt_d = 3'b001 << owner_d;
        case (owner_d)
          2'd0:    begin digits_d = ds.val0; dp_d = ds.dp0; sg_d = ds.sg0; end
          2'd1:    begin digits_d = ds.val1; dp_d = ds.dp1; sg_d = ds.sg1; end
          default: begin digits_d = ds.val2; dp_d = ds.dp2; sg_d = ds.sg2; end
        endcase
      end
      IDLE:    sg_d = 4'hF;
      default: sg_d = 4'h0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_q      <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
      ds.gnt    <= '0;
      ds.W      <= '0;
      ds.X      <= '0;
      ds.Y      <= '0;
      ds.Z      <= '0;
      ds.decPts <= '0;
      ds.signs  <= 4'hF;
    end else begin
      cnt_q     <= tick ? '0 : cnt_q + 1'b1;
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      hold_q    <= hold_d;
      ds.gnt    <= gnt_d;
      ds.W      <= digits_d[15:12];
      ds.X      <= digits_d[11:8];
      ds.Y      <= digits_d[7:4];
      ds.Z      <= digits_d[3:0];
      ds.decPts <= dp_d;
      ds.signs  <= sg_d;
    end
  end
endmodule

// File: tb/tb_display_share_arbiter.sv
// Directed bench for display_share_arbiter with TICK_DIV=4, MIN_HOLD=3, MAX_HOLD=6.
module tb_display_share_arbiter;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   edge_n = 0;

  display_share_if ds();

  display_share_arbiter #(.TICK_DIV(4), .MIN_HOLD(3), .MAX_HOLD(6)) dut (
    .CLK(CLK), .RESET(RESET), .ds(ds)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(negedge CLK);
    edge_n++;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) step();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    ds.req = 3'b000;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    edge_n = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ds.gnt !== 3'b000 || ds.signs !== 4'hF || {ds.W, ds.X, ds.Y, ds.Z} !== 16'h0 || ds.decPts !== 4'h0) begin
      failures++;
      $display("FAIL reset_state gnt=%b signs=%h digits=%h dp=%h want 000/f/0000/0", ds.gnt, ds.signs, {ds.W, ds.X, ds.Y, ds.Z}, ds.decPts);
    end
    ds.req = 3'b001;
    run_to(5);
    checks++;
    if (ds.gnt !== 3'b001) begin
      failures++;
      $display("FAIL reset_pre_own gnt=%b want 001", ds.gnt);
    end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (ds.gnt !== 3'b000 || ds.signs !== 4'hF || {ds.W, ds.X, ds.Y, ds.Z} !== 16'h0) begin
      failures++;
      $display("FAIL reset_async gnt=%b signs=%h digits=%h want 000/f/0000", ds.gnt, ds.signs, {ds.W, ds.X, ds.Y, ds.Z});
    end
    @(negedge CLK);
    ds.req = 3'b000;
    RESET = 1'b0;
    edge_n = 0;
    run_to(6);
    checks++;
    if (ds.gnt !== 3'b000 || ds.signs !== 4'hF) begin
      failures++;
      $display("FAIL reset_stay_idle gnt=%b signs=%h want 000/f", ds.gnt, ds.signs);
    end
  endtask

  task automatic test_single_req();
    do_reset();
    ds.val0 = 16'h1234; ds.dp0 = 4'b0100; ds.sg0 = 4'b0000;
    ds.req = 3'b001;
    step();
    checks++;
    if (ds.gnt !== 3'b001 || {ds.W, ds.X, ds.Y, ds.Z} !== 16'h1234 || ds.decPts !== 4'b0100) begin
      failures++;
      $display("FAIL single_grant gnt=%b digits=%h dp=%b want 001/1234/0100", ds.gnt, {ds.W, ds.X, ds.Y, ds.Z}, ds.decPts);
    end
    run_to(4);
    ds.req = 3'b000;
    run_to(12);
    checks++;
    if (ds.gnt !== 3'b001 || {ds.W, ds.X, ds.Y, ds.Z} !== 16'h1234) begin
      failures++;
      $display("FAIL single_min_hold gnt=%b digits=%h want 001/1234", ds.gnt, {ds.W, ds.X, ds.Y, ds.Z});
    end
    step();
    checks++;
    if (ds.gnt !== 3'b000 || ds.signs !== 4'h0 || {ds.W, ds.X, ds.Y, ds.Z} !== 16'h0 || ds.decPts !== 4'h0) begin
      failures++;
      $display("FAIL single_blank gnt=%b signs=%h digits=%h dp=%h want 000/0/0000/0", ds.gnt, ds.signs, {ds.W, ds.X, ds.Y, ds.Z}, ds.decPts);
    end
    run_to(15);
    checks++;
    if (ds.signs !== 4'h0) begin
      failures++;
      $display("FAIL single_blank_end signs=%h want 0", ds.signs);
    end
    step();
    checks++;
    if (ds.gnt !== 3'b000 || ds.signs !== 4'hF) begin
      failures++;
      $display("FAIL single_idle gnt=%b signs=%h want 000/f", ds.gnt, ds.signs);
    end
  endtask

  task automatic test_round_robin();
    int         ck_edge [12] = '{1, 24, 25, 27, 28, 52, 53, 55, 56, 80, 81, 84};
    logic [2:0] ck_gnt  [12] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b010, 3'b010,
                                 3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
    logic [3:0] ck_w    [12] = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2,
                                 4'h0, 4'h0, 4'h3, 4'h3, 4'h0, 4'h1};
    do_reset();
    ds.val0 = 16'h1111; ds.val1 = 16'h2222; ds.val2 = 16'h3333;
    ds.req = 3'b111;
    for (int i = 0; i < 12; i++) begin
      run_to(ck_edge[i]);
      checks++;
      if (ds.gnt !== ck_gnt[i] || ds.W !== ck_w[i]) begin
        failures++;
        $display("FAIL rr_edge%0d gnt=%b W=%h want %b/%h", ck_edge[i], ds.gnt, ds.W, ck_gnt[i], ck_w[i]);
      end
    end
  endtask

  task automatic test_preempt();
    do_reset();
    ds.req = 3'b001;
    run_to(8);
    ds.req = 3'b101;
    run_to(24);
    checks++;
    if (ds.gnt !== 3'b001) begin
      failures++;
      $display("FAIL preempt_hold gnt=%b want 001", ds.gnt);
    end
    step();
    checks++;
    if (ds.gnt !== 3'b000 || ds.signs !== 4'h0) begin
      failures++;
      $display("FAIL preempt_blank gnt=%b signs=%h want 000/0", ds.gnt, ds.signs);
    end
    run_to(27);
    checks++;
    if (ds.gnt !== 3'b000) begin
      failures++;
      $display("FAIL preempt_blank_len gnt=%b want 000", ds.gnt);
    end
    step();
    checks++;
    if (ds.gnt !== 3'b100) begin
      failures++;
      $display("FAIL preempt_next gnt=%b want 100", ds.gnt);
    end
  endtask

  task automatic test_no_competitor();
    int bad;
    bad = 0;
    do_reset();
    ds.req = 3'b010;
    for (int e = 1; e <= 80; e++) begin
      step();
      if (ds.gnt !== 3'b010) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL solo_hold bad_cycles=%0d want 0", bad);
    end
    ds.req = 3'b011;
    step();
    checks++;
    if (ds.gnt !== 3'b000) begin
      failures++;
      $display("FAIL solo_saturate gnt=%b want 000", ds.gnt);
    end
    run_to(84);
    checks++;
    if (ds.gnt !== 3'b001) begin
      failures++;
      $display("FAIL solo_next gnt=%b want 001", ds.gnt);
    end
  endtask

  task automatic test_live_data();
    do_reset();
    ds.val1 = 16'h00FF; ds.dp1 = 4'b0000; ds.sg1 = 4'b0000;
    ds.req = 3'b010;
    step();
    checks++;
    if ({ds.W, ds.X, ds.Y, ds.Z} !== 16'h00FF || ds.decPts !== 4'h0 || ds.signs !== 4'h0) begin
      failures++;
      $display("FAIL live_first digits=%h dp=%b sg=%b want 00ff/0000/0000", {ds.W, ds.X, ds.Y, ds.Z}, ds.decPts, ds.signs);
    end
    ds.val1 = 16'hABCD; ds.dp1 = 4'b1010; ds.sg1 = 4'b0101;
    step();
    checks++;
    if ({ds.W, ds.X, ds.Y, ds.Z} !== 16'hABCD || ds.decPts !== 4'b1010 || ds.signs !== 4'b0101) begin
      failures++;
      $display("FAIL live_follow digits=%h dp=%b sg=%b want abcd/1010/0101", {ds.W, ds.X, ds.Y, ds.Z}, ds.decPts, ds.signs);
    end
  endtask

  initial begin
    ds.req = 3'b000;
    ds.val0 = '0; ds.val1 = '0; ds.val2 = '0;
    ds.dp0 = '0; ds.dp1 = '0; ds.dp2 = '0;
    ds.sg0 = '0; ds.sg1 = '0; ds.sg2 = '0;
    test_reset();
    test_single_req();
    test_round_robin();
    test_preempt();
    test_no_competitor();
    test_live_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
